// File: rtl/i2s_mic_rx_if.sv
// Audio sample bus from the I2S microphone receiver to its downstream consumer.
// audio_valid is a one-cycle strobe with no ready: the consumer must take every pulse.
interface i2s_mic_rx_if;
    logic [15:0] pcm_out;
    logic        audio_valid;

    modport master (output pcm_out, output audio_valid);
    modport slave  (input  pcm_out, input  audio_valid);
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: generates bclk/ws for a 24-bit MEMS mic, captures one channel,
// applies power-of-two gain with saturation and emits a 16-bit PCM sample per frame.
module i2s_mic_rx #(
    parameter int CLK_DIV    = 12,
    parameter int CHANNEL    = 0,
    parameter int GAIN_SHIFT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         sd,
    output logic         bclk,
    output logic         ws,
    output logic         state_dbg,
    i2s_mic_rx_if.master audio
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_cnt;
    logic [5:0]         slot;
    logic [5:0]         slot_nx;
    logic [23:0]        shreg;
    logic [23:0]        shift_nx;
    logic [23:0]        sat24;
    logic signed [31:0] ext;
    logic signed [31:0] gained;
    logic               sd_m, sd_s;
    logic               fall_edge, in_win, capture, last_bit;

    assign state_dbg = (state_q == RUN);
    assign fall_edge = (state_q == RUN) && (div_cnt == DIV_LAST) && bclk;
    assign in_win    = (slot[4:0] >= 5'd1) && (slot[4:0] <= 5'd24);
    assign capture   = fall_edge && (slot[5] == 1'(CHANNEL)) && in_win;
    assign last_bit  = (slot[4:0] == 5'd24);
    assign shift_nx  = {shreg[22:0], sd_s};
    assign slot_nx   = slot + 6'd1;

    // Gain is applied to the word including the bit being captured this cycle,
    // so the sample is ready in the same edge that completes the shift.
    always_comb begin
        ext    = {{8{shift_nx[23]}}, shift_nx};
        gained = ext <<< GAIN_SHIFT;
        sat24  = gained[23:0];
        if (gained > 32'sh007F_FFFF)
            sat24 = 24'h7F_FFFF;
        else if (gained < 32'shFF80_0000)
            sat24 = 24'h80_0000;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (fall_edge && (slot == 6'd63) && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sd_m    <= 1'b0;
            sd_s    <= 1'b0;
        end else begin
            state_q <= state_d;
            sd_m    <= sd;
            sd_s    <= sd_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt           <= '0;
            bclk              <= 1'b0;
            ws                <= 1'b0;
            slot              <= '0;
            shreg             <= '0;
            audio.pcm_out     <= '0;
            audio.audio_valid <= 1'b0;
        end else begin
            audio.audio_valid <= 1'b0;
            if (state_q == IDLE) begin
                div_cnt <= '0;
                bclk    <= 1'b0;
                ws      <= 1'b0;
                slot    <= '0;
                shreg   <= '0;
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    bclk    <= ~bclk;
                    // Falling bclk opens the next slot; slot 63 wraps to 0, which also
                    // leaves bclk/ws low when the frame ends into IDLE.
                    if (bclk) begin
                        slot <= slot_nx;
                        ws   <= slot_nx[5];
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (capture) begin
                    shreg <= shift_nx;
                    if (last_bit) begin
                        audio.pcm_out     <= sat24[23:8];
                        audio.audio_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: four instances (gain/channel variants) share clk, reset and en,
// each fed by its own mic model that drives sd on bclk falling edges.
module tb_i2s_mic_rx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        bclk_w[4];
    logic        ws_w[4];
    logic        run_w[4];
    logic        valid_w[4];
    logic [15:0] pcm_w[4];
    logic [23:0] left_w[4];
    logic [23:0] right_w[4];
    int          pcnt[4] = '{0, 0, 0, 0};
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic mic_bit(input int s, input logic [23:0] l, input logic [23:0] r);
        int k;
        logic [23:0] w;
        k = s % 32;
        w = (s < 32) ? l : r;
        if (k >= 1 && k <= 24) return w[24-k];
        return 1'b1;
    endfunction

    // Instance 0: ch0 gain0; 1: ch0 gain4; 2: ch0 gain2; 3: ch1 gain0.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic sd_g = 1'b1;
        int   slot_g = 0;
        i2s_mic_rx_if aif ();

        i2s_mic_rx #(
            .CLK_DIV   (4),
            .CHANNEL   ((g == 3) ? 1 : 0),
            .GAIN_SHIFT((g == 1) ? 4 : ((g == 2) ? 2 : 0))
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .sd       (sd_g),
            .bclk     (bclk_w[g]),
            .ws       (ws_w[g]),
            .state_dbg(run_w[g]),
            .audio    (aif.master)
        );

        assign valid_w[g] = aif.audio_valid;
        assign pcm_w[g]   = aif.pcm_out;

        always @(negedge bclk_w[g] or negedge run_w[g]) begin
            if (!run_w[g]) slot_g = 0;
            else slot_g = (slot_g + 1) % 64;
            sd_g = mic_bit(slot_g, left_w[g], right_w[g]);
        end
    end

    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (valid_w[i]) pcnt[i]++;

    task automatic wait_pulse(input int idx, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid_w[idx] && cycles < budget);
        if (!valid_w[idx]) cycles = -1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_vec += 4;
            if (bclk_w[i] !== 1'b0) begin n_err++; $display("FAIL reset_bclk[%0d]: got %b want 0", i, bclk_w[i]); end
            if (ws_w[i] !== 1'b0) begin n_err++; $display("FAIL reset_ws[%0d]: got %b want 0", i, ws_w[i]); end
            if (valid_w[i] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_w[i]); end
            if (pcm_w[i] !== 16'h0000) begin n_err++; $display("FAIL reset_pcm[%0d]: got %h want 0000", i, pcm_w[i]); end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_frame;
        int c;
        left_w[0] = 24'h123456; right_w[0] = 24'hABCDEF;
        left_w[1] = 24'h012345; right_w[1] = 24'h000000;
        left_w[2] = 24'h400000; right_w[2] = 24'h000000;
        left_w[3] = 24'h000000; right_w[3] = 24'h7F0000;
        en = 1'b1;
        wait_pulse(0, 400, c);
        n_vec += 6;
        if (c !== 201) begin n_err++; $display("FAIL first_latency: got %0d want 201", c); end
        if (pcm_w[0] !== 16'h1234) begin n_err++; $display("FAIL basic_pcm: got %h want 1234", pcm_w[0]); end
        if (pcm_w[1] !== 16'h1234) begin n_err++; $display("FAIL gain4_pcm: got %h want 1234", pcm_w[1]); end
        if (pcm_w[2] !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos_pcm: got %h want 7fff", pcm_w[2]); end
        if (bclk_w[0] !== 1'b0) begin n_err++; $display("FAIL pulse_bclk: got %b want 0", bclk_w[0]); end
        if (ws_w[0] !== 1'b0) begin n_err++; $display("FAIL pulse_ws_ch0: got %b want 0", ws_w[0]); end
        @(negedge clk);
        n_vec++;
        if (valid_w[0] !== 1'b0) begin n_err++; $display("FAIL valid_width: got %b want 0", valid_w[0]); end
        left_w[2] = 24'hC00000;
    endtask

    task automatic test_channel1;
        int c;
        wait_pulse(3, 400, c);
        n_vec += 3;
        if (c !== 255) begin n_err++; $display("FAIL ch1_offset: got %0d want 255", c); end
        if (pcm_w[3] !== 16'h7F00) begin n_err++; $display("FAIL ch1_pcm: got %h want 7f00", pcm_w[3]); end
        if (ws_w[3] !== 1'b1) begin n_err++; $display("FAIL ch1_ws: got %b want 1", ws_w[3]); end
    endtask

    task automatic test_back_to_back;
        int c;
        int s;
        wait_pulse(0, 400, c);
        n_vec += 3;
        if (c !== 256) begin n_err++; $display("FAIL spacing_a: got %0d want 256", c); end
        if (pcm_w[0] !== 16'h1234) begin n_err++; $display("FAIL basic_pcm2: got %h want 1234", pcm_w[0]); end
        if (pcm_w[2] !== 16'h8000) begin n_err++; $display("FAIL sat_neg_pcm: got %h want 8000", pcm_w[2]); end
        @(negedge clk);
        s = pcnt[0];
        left_w[2] = 24'hFFFFFF;
        wait_pulse(0, 600, c);
        @(negedge clk);
        n_vec += 3;
        if (c !== 511) begin n_err++; $display("FAIL spacing_b: got %0d want 511", c); end
        if (pcm_w[2] !== 16'hFFFF) begin n_err++; $display("FAIL sat_m1_pcm: got %h want ffff", pcm_w[2]); end
        if (pcnt[0] - s !== 1) begin n_err++; $display("FAIL pulses_per_frame: got %0d want 1", pcnt[0] - s); end
    endtask

    task automatic test_en_low;
        int c;
        int s;
        int hi;
        left_w[0] = 24'h5A5A5A;
        repeat (395) @(negedge clk);
        en = 1'b0;
        wait_pulse(0, 200, c);
        n_vec += 2;
        if (c !== 116) begin n_err++; $display("FAIL enlow_pulse_time: got %0d want 116", c); end
        if (pcm_w[0] !== 16'h5A5A) begin n_err++; $display("FAIL enlow_pcm: got %h want 5a5a", pcm_w[0]); end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (run_w[0] && c < 500);
        n_vec++;
        if (c !== 312) begin n_err++; $display("FAIL enlow_idle_time: got %0d want 312", c); end
        s = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        hi = 0;
        repeat (600) begin
            @(negedge clk);
            if (bclk_w[0] !== 1'b0 || ws_w[0] !== 1'b0) hi++;
        end
        n_vec += 2;
        if (hi !== 0) begin n_err++; $display("FAIL idle_clocks: got %0d active cycles want 0", hi); end
        if (pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - s !== 0) begin
            n_err++; $display("FAIL idle_pulses: got %0d want 0", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - s);
        end
        left_w[0] = 24'h246800;
        en = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bclk_w[0] && c < 20);
        n_vec++;
        if (c !== 5) begin n_err++; $display("FAIL reentry_rise: got %0d want 5", c); end
    endtask

    task automatic test_reset_mid;
        int c;
        int s;
        s = pcnt[0];
        repeat (160) @(negedge clk);
        n_vec++;
        if (bclk_w[0] !== 1'b1) begin n_err++; $display("FAIL slot20_bclk: got %b want 1", bclk_w[0]); end
        reset_n = 1'b0;
        en = 1'b0;
        #1;
        n_vec += 5;
        if (bclk_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_bclk: got %b want 0", bclk_w[0]); end
        if (ws_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_ws: got %b want 0", ws_w[0]); end
        if (pcm_w[0] !== 16'h0000) begin n_err++; $display("FAIL rst_pcm: got %h want 0000", pcm_w[0]); end
        if (valid_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_w[0]); end
        if (run_w[0] !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", run_w[0]); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        n_vec++;
        if (pcnt[0] !== s) begin n_err++; $display("FAIL aborted_pulse: got %0d want %0d", pcnt[0], s); end
        en = 1'b1;
        wait_pulse(0, 400, c);
        n_vec += 2;
        if (c !== 201) begin n_err++; $display("FAIL post_rst_latency: got %0d want 201", c); end
        if (pcm_w[0] !== 16'h2468) begin n_err++; $display("FAIL post_rst_pcm: got %h want 2468", pcm_w[0]); end
        en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            left_w[i]  = 24'h0;
            right_w[i] = 24'h0;
        end
        test_reset;
        test_first_frame;
        test_channel1;
        test_back_to_back;
        test_en_low;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within 1 ms");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

I2S master receiver for the karaoke microphone path. It generates the bit clock (`bclk`) and word select (`ws`) for a 24-bit I2S MEMS microphone, and deserialises one channel. It applies a power-of-two digital gain with saturation, then delivers a 16-bit PCM sample with a one-cycle `audio_valid` strobe. Its `pcm_out`/`audio_valid` feed the downstream SPI transmitter in the `clk` domain.

## Interface
- `CLK_DIV`, default 12: `clk` cycles per `bclk` half-period; legal range ≥ 3.
- `CHANNEL`, default 0: captured slot; 0 = left (`ws` low), 1 = right (`ws` high).
- `GAIN_SHIFT`, default 0: arithmetic left shift applied to the 24-bit sample; legal range 0–7.
- `clk` input, 1 bit: system clock; all logic runs on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: run request, synchronous to `clk`.
- `sd` input, 1 bit: microphone serial data; asynchronous to `clk`.
- `bclk` output, 1 bit: I2S bit clock, registered.
- `ws` output, 1 bit: I2S word select, registered.
- `pcm_out` output, 16 bits: signed sample; held until the next update.
- `audio_valid` output, 1 bit: one-`clk` pulse marking a new `pcm_out`.

## Operation
- `sd` passes through a 2-flop synchronizer (`sd_s`) before any use.
- States:
  - IDLE: `bclk` = 0, `ws` = 0, counters cleared.
  - RUN: frame generation.
- Transitions:
  - IDLE→RUN on the first `clk` edge with `en` = 1.
  - RUN→IDLE only at the end of slot 63, and only if `en` = 0 at that moment.
  - Deasserting `en` mid-frame therefore always completes the current frame, including delivery of any pending sample.
- Frame structure: 64 slots, indexed 0–63.
  - Each slot is `bclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `ws` = 0 in slots 0–31 and 1 in slots 32–63.
  - `ws` changes in the same cycle that `bclk` falls into slot 0 or slot 32.
- Bit position k = slot mod 32.
  - Standard I2S one-bit delay: the MSB is at k = 1.
  - Data bits occupy k = 1..24; k = 0 and k = 25..31 are ignored.
- Capture timing: `sd_s` is sampled on the last cycle of each slot's high phase, i.e. the cycle before `bclk` falls.
  - Bits shift MSB-first into a 24-bit register, only during the slot range matching `CHANNEL`.
  - The 2-cycle synchronizer lag stays inside the bit window because `CLK_DIV` ≥ 3.
- Arithmetic: s24 (signed) is sign-extended to 32 bits, then shifted left by `GAIN_SHIFT`.
  - The result is saturated to [−2^23, 2^23−1].
  - `pcm_out` = saturated[23:8], i.e. truncation with no rounding.
- Other slot data (k outside 1–24, or the unselected channel) never affects `pcm_out`.

## Timing
- Reset values: `bclk` = 0, `ws` = 0, `pcm_out` = 0x0000, `audio_valid` = 0; state IDLE; shift register and counters = 0.
- Reset asserted mid-frame aborts immediately; no `audio_valid` is produced for the partial sample.
- First `bclk` rise occurs `CLK_DIV` cycles after entering RUN.
- `pcm_out` update and `audio_valid` pulse happen in the same cycle: the `clk` cycle after the k = 24 capture of the selected channel.
- `audio_valid` is high for exactly 1 cycle per frame.
- Pulse spacing is exactly 128·`CLK_DIV` cycles; the default gives 1536 cycles, i.e. 31.25 kHz at 48 MHz.
- There is no back-pressure: the consumer must accept every pulse.
- `en` toggling within a frame has no effect until the end of slot 63.
- IDLE→RUN re-entry always starts at slot 0.

## Test plan
- All scenarios use `CLK_DIV` = 4, `CHANNEL` = 0, and a mic model that drives on `bclk` falling edges.
- Basic capture, `GAIN_SHIFT` = 0: left = 0x123456, right = 0xABCDEF → `pcm_out` = 0x1234, a single pulse, and 512 cycles between subsequent pulses.
- Gain, `GAIN_SHIFT` = 4: left = 0x012345 → `pcm_out` = 0x1234.
- Saturation, `GAIN_SHIFT` = 2:
  - left = 0x400000 → 0x7FFF.
  - left = 0xC00000 → 0x8000.
  - left = 0xFFFFFF → 0xFFFF.
- `CHANNEL` = 1: right = 0x7F0000, left = 0x000000 → 0x7F00.
  - `audio_valid` fires after slot 56's capture, not slot 24's.
- `en` low at slot 10: the current frame completes with a valid pulse carrying the slot data.
  - Afterwards `bclk` stays 0 and `ws` = 0, with no further pulses.
  - Re-asserting `en` → first `bclk` rise after 4 cycles.
- `reset_n` pulsed low during slot 20:
  - All outputs return to reset values immediately.
  - No pulse for the aborted frame.
  - Clean capture on the next full frame after `en`.
